// File: rtl/spi_acl_responder_if.sv
// SPI bus bundle between an external mode-0 master and spi_acl_responder.
// The master modport drives the serial clock, data and select; the slave drives miso.
interface spi_acl_responder_if;
  logic sclk;
  logic mosi;
  logic ss_n;
  logic miso;

  modport master (output sclk, output mosi, output ss_n, input miso);
  modport slave  (input sclk, input mosi, input ss_n, output miso);
endinterface

// File: rtl/spi_acl_responder.sv
// SPI mode-0 register-file responder: 0x0A write / 0x0B read bursts plus a local port.
// Define SPI_ACL_RO_ID_EN to make addresses 0x00-0x02 read-only ID bytes 0xAD/0x1D/0xF2.
module spi_acl_responder #(
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  spi_acl_responder_if.slave spi,
  input  logic               reg_wr,
  input  logic [ADDR_W-1:0]  reg_addr,
  input  logic [7:0]         reg_wr_data,
  output logic [7:0]         reg_rd_data,
  output logic               xfer_done
);

  localparam int         NREGS     = 2 ** ADDR_W;
  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGN} state_t;

  state_t            r_state;
  state_t            w_nextState;

  logic [2:0]        r_sclkSync;
  logic [2:0]        r_ssSync;
  logic [1:0]        r_mosiSync;
  logic [1:0]        r_settle;
  logic              r_armed;
  logic [2:0]        r_bitCnt;
  logic [7:0]        r_rx;
  logic [7:0]        r_tx;
  logic              r_opRead;
  logic              r_skipShift;
  logic              r_miso;
  logic              r_xferDone;
  logic [7:0]        r_rdData;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_regs [NREGS];

  logic              w_sclkRise;
  logic              w_sclkFall;
  logic              w_ssFall;
  logic              w_ssRise;
  logic              w_abort;
  logic              w_shiftIn;
  logic              w_byteDone;
  logic              w_spiWr;
  logic              w_spiWrEn;
  logic              w_localWrEn;
  logic [7:0]        w_rxByte;
  logic [7:0]        w_spiRdData;
  logic [7:0]        w_localRdData;
  logic [ADDR_W-1:0] w_ptrNext;
  logic [ADDR_W-1:0] w_spiRdAddr;

  // r_armed blocks a select that was already low through reset from looking like a new falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclkSync <= '0;
      r_ssSync   <= '1;
      r_mosiSync <= '0;
      r_settle   <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_sclkSync <= {r_sclkSync[1:0], spi.sclk};
      r_ssSync   <= {r_ssSync[1:0], spi.ss_n};
      r_mosiSync <= {r_mosiSync[0], spi.mosi};
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
      if (r_settle == 2'd3 && r_ssSync[2]) r_armed <= 1'b1;
    end
  end

  assign w_sclkRise  = r_sclkSync[1] & ~r_sclkSync[2];
  assign w_sclkFall  = ~r_sclkSync[1] & r_sclkSync[2];
  assign w_ssFall    = r_armed & r_ssSync[2] & ~r_ssSync[1];
  assign w_ssRise    = r_ssSync[1] & ~r_ssSync[2];
  assign w_abort     = w_ssRise && (r_state != IDLE);
  assign w_shiftIn   = w_sclkRise && !w_abort &&
                       (r_state == CMD || r_state == ADDR || r_state == DATA);
  assign w_byteDone  = w_shiftIn && (r_bitCnt == 3'd7);
  assign w_rxByte    = {r_rx[6:0], r_mosiSync[1]};
  assign w_ptrNext   = r_ptr + ADDR_W'(1);
  assign w_spiRdAddr = (r_state == ADDR) ? w_rxByte[ADDR_W-1:0] : w_ptrNext;
  assign w_spiWr     = w_byteDone && (r_state == DATA) && !r_opRead;

`ifdef SPI_ACL_RO_ID_EN
  function automatic logic isId(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(3);
  endfunction

  function automatic logic [7:0] idByte(input logic [ADDR_W-1:0] a);
    case (a)
      ADDR_W'(0): return 8'hAD;
      ADDR_W'(1): return 8'h1D;
      default:    return 8'hF2;
    endcase
  endfunction

  assign w_spiRdData   = isId(w_spiRdAddr) ? idByte(w_spiRdAddr) : r_regs[w_spiRdAddr];
  assign w_localRdData = isId(reg_addr) ? idByte(reg_addr) : r_regs[reg_addr];
  assign w_spiWrEn     = w_spiWr && !isId(r_ptr);
  assign w_localWrEn   = reg_wr && !isId(reg_addr);
`else
  assign w_spiRdData   = r_regs[w_spiRdAddr];
  assign w_localRdData = r_regs[reg_addr];
  assign w_spiWrEn     = w_spiWr;
  assign w_localWrEn   = reg_wr;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (w_abort) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_ssFall) w_nextState = CMD;
        CMD:  if (w_byteDone)
                w_nextState = (w_rxByte == CMD_WRITE || w_rxByte == CMD_READ) ? ADDR : IGN;
        ADDR: if (w_byteDone) w_nextState = DATA;
        DATA: w_nextState = DATA;
        IGN:  w_nextState = IGN;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // The transmit register is reloaded on the last rising edge of each ADDR/DATA byte of a read;
  // the falling edge right after a reload must not shift, or bit 7 would never reach the master.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitCnt    <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_opRead    <= 1'b0;
      r_skipShift <= 1'b0;
      r_ptr       <= '0;
      r_miso      <= 1'b0;
      r_xferDone  <= 1'b0;
    end else begin
      r_xferDone <= w_abort;
      r_miso     <= (r_state == DATA && r_opRead) ? r_tx[7] : 1'b0;
      if (w_abort || (r_state == IDLE && w_ssFall)) begin
        r_bitCnt    <= '0;
        r_rx        <= '0;
        r_tx        <= '0;
        r_skipShift <= 1'b0;
      end else if (w_shiftIn) begin
        r_rx     <= w_rxByte;
        r_bitCnt <= r_bitCnt + 3'd1;
        if (w_byteDone) begin
          case (r_state)
            CMD:     r_opRead <= (w_rxByte == CMD_READ);
            ADDR:    r_ptr    <= w_rxByte[ADDR_W-1:0];
            DATA:    r_ptr    <= w_ptrNext;
            default: r_ptr    <= r_ptr;
          endcase
          if (r_opRead && r_state != CMD) begin
            r_tx        <= w_spiRdData;
            r_skipShift <= 1'b1;
          end
        end
      end else if (r_state == DATA && r_opRead && w_sclkFall) begin
        if (r_skipShift) r_skipShift <= 1'b0;
        else             r_tx        <= {r_tx[6:0], 1'b0};
      end
    end
  end

  // The SPI write is placed last so it wins a same-cycle collision with a local write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_rdData <= '0;
    end else begin
      if (w_localWrEn) r_regs[reg_addr] <= reg_wr_data;
      if (w_spiWrEn)   r_regs[r_ptr]    <= w_rxByte;
      r_rdData <= w_localRdData;
    end
  end

  assign spi.miso    = r_miso & ~spi.ss_n;
  assign xfer_done   = r_xferDone;
  assign reg_rd_data = r_rdData;

endmodule

// File: tb/tb_spi_acl_responder.sv
// Self-checking bench for spi_acl_responder: directed scenarios plus random SPI and local
// traffic, compared against a byte-level register-file model.
`timescale 1ns/1ps
module tb_spi_acl_responder;
  localparam int ADDR_W = 6;
  localparam int NREGS  = 64;
  localparam int HALF   = 60;

  logic              clk = 1'b0;
  logic              reset;
  logic              regWr;
  logic [ADDR_W-1:0] regAddr;
  logic [7:0]        regWrData;
  logic [7:0]        regRdData;
  logic              xferDone;

  spi_acl_responder_if spiBus();

  spi_acl_responder #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi         (spiBus),
    .reg_wr      (regWr),
    .reg_addr    (regAddr),
    .reg_wr_data (regWrData),
    .reg_rd_data (regRdData),
    .xfer_done   (xferDone)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  int doneCount   = 0;
  int expDone     = 0;
  int misoLeak    = 0;

  logic [7:0] mem   [NREGS];
  logic [7:0] txBuf [8];
  logic [7:0] rxBuf [8];
  logic [7:0] expRx [8];
  logic [7:0] scratch;

  always @(posedge clk) if (xferDone === 1'b1) doneCount++;
  always @(negedge clk) if (spiBus.ss_n === 1'b1 && spiBus.miso !== 1'b0) misoLeak++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] modelRead(input int a);
`ifdef SPI_ACL_RO_ID_EN
    if (a == 0) return 8'hAD;
    if (a == 1) return 8'h1D;
    if (a == 2) return 8'hF2;
`endif
    return mem[a];
  endfunction

  function automatic void modelWrite(input int a, input logic [7:0] d);
`ifdef SPI_ACL_RO_ID_EN
    if (a < 3) return;
`endif
    mem[a] = d;
  endfunction

  // Only completed bytes matter: a trailing partial byte is neither written nor compared
  task automatic predictSpi(input int nBytes);
    int ptr;
    for (int i = 0; i < 8; i++) expRx[i] = 8'h00;
    if (nBytes >= 2 && (txBuf[0] == 8'h0A || txBuf[0] == 8'h0B)) begin
      ptr = int'(txBuf[1]) % NREGS;
      for (int i = 2; i < nBytes; i++) begin
        if (txBuf[0] == 8'h0B) expRx[i] = modelRead(ptr);
        else modelWrite(ptr, txBuf[i]);
        ptr = (ptr + 1) % NREGS;
      end
    end
  endtask

  task automatic spiByte(input logic [7:0] txb, input int nBits, output logic [7:0] rxb);
    rxb = 8'h00;
    for (int i = 7; i >= 8 - nBits; i--) begin
      spiBus.mosi = txb[i];
      #(HALF);
      rxb[i] = spiBus.miso;
      spiBus.sclk = 1'b1;
      #(HALF);
      spiBus.sclk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input string tag, input int nBytes, input int cutBits);
    predictSpi(nBytes);
    @(negedge clk);
    spiBus.ss_n = 1'b0;
    for (int b = 0; b < nBytes; b++) spiByte(txBuf[b], 8, rxBuf[b]);
    if (cutBits > 0) spiByte(txBuf[nBytes], cutBits, scratch);
    #(HALF);
    spiBus.ss_n = 1'b1;
    expDone++;
    #(HALF * 2);
    for (int b = 0; b < nBytes; b++)
      checkOutput($sformatf("%s.rx%0d", tag, b), rxBuf[b], expRx[b]);
    checkOutput({tag, ".done"}, doneCount, expDone);
  endtask

  task automatic localWrite(input int a, input logic [7:0] d);
    @(negedge clk);
    regWr     = 1'b1;
    regAddr   = ADDR_W'(a);
    regWrData = d;
    @(negedge clk);
    regWr = 1'b0;
    modelWrite(a, d);
  endtask

  task automatic localRead(input string tag, input int a);
    @(negedge clk);
    regAddr = ADDR_W'(a);
    @(negedge clk);
    checkOutput($sformatf("%s@%02h", tag, a), regRdData, modelRead(a));
  endtask

  initial begin
    #(2ms);
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    failCount++;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    int kind, n, cut;
    reset = 1'b1;
    regWr = 1'b0; regAddr = '0; regWrData = '0;
    spiBus.sclk = 1'b0; spiBus.mosi = 1'b0; spiBus.ss_n = 1'b1;
    for (int i = 0; i < NREGS; i++) mem[i] = 8'h00;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    checkOutput("rstRdData", regRdData, 8'h00);
    checkOutput("rstMiso", spiBus.miso, 1'b0);
    checkOutput("rstDone", xferDone, 1'b0);
    localRead("rstReg", 0);
    localRead("rstReg", 63);

    // Local write then SPI burst read
    localWrite(8, 8'h5A);
    txBuf[0] = 8'h0B; txBuf[1] = 8'h08; txBuf[2] = 8'h00;
    applyStimulus("rd08", 3, 0);
    checkOutput("rd08.value", rxBuf[2], 8'h5A);

    // SPI write wrapping 0x3F -> 0x00
    txBuf[0] = 8'h0A; txBuf[1] = 8'h3F; txBuf[2] = 8'h11; txBuf[3] = 8'h22;
    applyStimulus("wrWrap", 4, 0);
    localRead("wrWrap", 63);
    localRead("wrWrap", 0);
`ifndef SPI_ACL_RO_ID_EN
    checkOutput("wrWrap.reg00", regRdData, 8'h22);
`endif

    // Unknown command is ignored
    txBuf[0] = 8'h55; txBuf[1] = 8'h08; txBuf[2] = 8'hFF; txBuf[3] = 8'hFF;
    applyStimulus("ign", 4, 0);
    localRead("ign", 8);

    // Partial data byte must not write
    localWrite(16, 8'h77);
    txBuf[0] = 8'h0A; txBuf[1] = 8'h10; txBuf[2] = 8'hC3;
    applyStimulus("cut", 2, 4);
    localRead("cut", 16);

`ifdef SPI_ACL_RO_ID_EN
    localWrite(3, 8'h3C);
    txBuf[0] = 8'h0B; txBuf[1] = 8'h00;
    for (int i = 2; i < 6; i++) txBuf[i] = 8'h00;
    applyStimulus("idRd", 6, 0);
    checkOutput("idRd.b0", rxBuf[2], 8'hAD);
    checkOutput("idRd.b1", rxBuf[3], 8'h1D);
    checkOutput("idRd.b2", rxBuf[4], 8'hF2);
    checkOutput("idRd.b3", rxBuf[5], 8'h3C);
    txBuf[0] = 8'h0A; txBuf[1] = 8'h01; txBuf[2] = 8'h00;
    applyStimulus("idWr", 3, 0);
    localRead("idWr", 1);
    localWrite(2, 8'h00);
    localRead("idLocalWr", 2);
`endif

    // Reset in the middle of a read, with select still low afterwards
    @(negedge clk);
    spiBus.ss_n = 1'b0;
    spiByte(8'h0B, 8, scratch);
    spiByte(8'h08, 8, scratch);
    spiByte(8'h00, 3, scratch);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) mem[i] = 8'h00;
    repeat (4) @(negedge clk);
    checkOutput("midRst.miso", spiBus.miso, 1'b0);
    spiByte(8'hFF, 5, scratch);
    checkOutput("midRst.misoClk", spiBus.miso, 1'b0);
    spiBus.ss_n = 1'b1;
    #(HALF * 2);
    checkOutput("midRst.noDone", doneCount, expDone);
    txBuf[0] = 8'h0B; txBuf[1] = 8'h08; txBuf[2] = 8'h00; txBuf[3] = 8'h00;
    applyStimulus("postRst", 4, 0);
    checkOutput("postRst.value", rxBuf[2], 8'h00);

    // Random mix of local and SPI traffic
    for (int it = 0; it < 30; it++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: localWrite(int'($urandom_range(0, NREGS - 1)), 8'($urandom));
        1: localRead("rndLocal", int'($urandom_range(0, NREGS - 1)));
        2, 3: begin
          n   = int'($urandom_range(3, 6));
          cut = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
          txBuf[0] = (kind == 2) ? 8'h0A : 8'h0B;
          for (int i = 1; i < 8; i++) txBuf[i] = 8'($urandom);
          applyStimulus((kind == 2) ? "rndWr" : "rndRd", n, cut);
        end
        default: begin
          n = int'($urandom_range(1, 4));
          do txBuf[0] = 8'($urandom); while (txBuf[0] == 8'h0A || txBuf[0] == 8'h0B);
          for (int i = 1; i < 8; i++) txBuf[i] = 8'($urandom);
          applyStimulus("rndIgn", n, 0);
        end
      endcase
    end
    for (int i = 0; i < 4; i++) localRead("final", int'($urandom_range(0, NREGS - 1)));

    checkOutput("misoWhileDeselected", misoLeak, 0);
    checkOutput("doneTotal", doneCount, expDone);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/spi_acl_responder.md
SPI_ACL_RESPONDER -- requirements
Module: spi_acl_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, register-file address width (2**ADDR_W 8-bit registers).
REQ-002 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port sclk  input  1  SPI serial clock from the master, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-005 The block SHALL have port mosi  input  1  SPI master-out data, MSB first.
REQ-006 The block SHALL have port ss_n  input  1  SPI slave select, active low.
REQ-007 The block SHALL have port miso  output  1  SPI master-in data, MSB first.
REQ-008 The block SHALL have port reg_wr  input  1  local write strobe into the register file.
REQ-009 The block SHALL have port reg_addr  input  ADDR_W  local read/write address.
REQ-010 The block SHALL have port reg_wr_data  input  8  local write data.
REQ-011 The block SHALL have port reg_rd_data  output  8  local read data, registered.
REQ-012 The block SHALL have port xfer_done  output  1  one-cycle pulse at the end of each selected transaction.

Function
REQ-013 The block SHALL pass sclk, mosi and ss_n through two-flop synchronizers; edge detection SHALL use a third stage on sclk and ss_n.
REQ-014 The block SHALL operate correctly for sclk high and low times of at least 4 clk cycles each.
REQ-015 The block SHALL implement states IDLE, CMD, ADDR, DATA and IGN.
REQ-016 IDLE -> CMD on a synchronized ss_n falling edge; the bit counter SHALL clear to 0.
REQ-017 The block SHALL shift mosi into an 8-bit receive register on each synchronized sclk rising edge while in CMD, ADDR or DATA.
REQ-018 After 8 bits in CMD: byte 0x0A -> ADDR with op=write; byte 0x0B -> ADDR with op=read; any other byte -> IGN.
REQ-019 After 8 bits in ADDR, the block SHALL latch the pointer from the low ADDR_W bits of the byte and enter DATA.
REQ-020 For a read, the 8th sclk rising edge of each ADDR or DATA byte SHALL load the transmit register with reg[pointer]; miso SHALL show its bit 7 within 3 clk cycles of that edge.
REQ-021 In a read DATA byte, each synchronized sclk falling edge SHALL shift the transmit register left, except the falling edge that immediately follows a load.
REQ-022 For a write, the 8th sclk rising edge of each DATA byte SHALL write the received byte to reg[pointer].
REQ-023 After each complete DATA byte, the pointer SHALL increment modulo 2**ADDR_W; 63 SHALL wrap to 0 for the default width.
REQ-024 For a read, the load at the end of a DATA byte SHALL use the incremented pointer.
REQ-025 miso SHALL be 0 in IDLE, CMD, ADDR (before the load) and IGN, and whenever ss_n is high.
REQ-026 A synchronized ss_n rising edge in any non-IDLE state SHALL force IDLE, discard any partial byte, and pulse xfer_done for one cycle.
REQ-027 When reg_wr is high, the block SHALL write reg_wr_data to reg[reg_addr].
REQ-028 When an SPI write and reg_wr target the same address in the same cycle, the SPI write SHALL take effect.
REQ-029 reg_rd_data SHALL equal reg[reg_addr] one cycle after reg_addr is presented.

Reset
REQ-030 Reset SHALL force IDLE and clear the bit counter, pointer, shift registers, synchronizers (ss_n stages to 1), miso, xfer_done, reg_rd_data and all registers to 0.
REQ-031 A reset asserted mid-transaction SHALL abort it without a write and without an xfer_done pulse; the block SHALL then wait in IDLE for a fresh ss_n falling edge.

Configuration
REQ-032 With macro SPI_ACL_RO_ID_EN defined, addresses 0x00, 0x01, 0x02 SHALL read 0xAD, 0x1D, 0xF2 over both SPI and the local port.
REQ-033 With SPI_ACL_RO_ID_EN defined, SPI and local writes to 0x00-0x02 SHALL be ignored, while the pointer still increments.
REQ-034 Without SPI_ACL_RO_ID_EN defined, 0x00-0x02 SHALL be ordinary read/write registers that reset to 0.

Verification
REQ-035 Scenario: local write 0x5A to address 0x08, then SPI read 0x0B,0x08,dummy -> third byte on miso = 0x5A; xfer_done pulses once.
REQ-036 Scenario: SPI write 0x0A,0x3F,0x11,0x22 -> reg[0x3F]=0x11 and reg[0x00]=0x22 (wrap; ID macro off); local reads confirm.
REQ-037 Scenario: SPI command 0x55 followed by 3 bytes -> miso stays 0 throughout; no register changes; xfer_done pulses.
REQ-038 Scenario: ss_n deasserted after 4 bits of a write data byte to address 0x10 -> reg[0x10] keeps its old value.
REQ-039 Scenario: SPI_ACL_RO_ID_EN on, burst read from 0x00 of 4 bytes -> 0xAD,0x1D,0xF2,reg[0x03]; SPI write 0x00 to 0x01 -> still reads 0x1D.
REQ-040 Scenario: reset pulsed mid-read, then a new SPI read of 0x08 -> returns 0x00; no stale bits on miso.
